// File: rtl/alarm_if.sv
// alarm_if: operator-side inputs and alarm outputs of the alarm controller
interface alarm_if #(
    parameter int N_CH = 4
);
    logic            enable_i;
    logic [N_CH-1:0] low_level_indicator_i;
    logic [N_CH-1:0] error_indicator_i;
    logic            ack_i;
    logic            alarm_state_o;
    logic            alarm_blink_o;
    logic [N_CH-1:0] alarm_cause_o;
    logic            new_fault_o;

    modport master (
        output enable_i, low_level_indicator_i, error_indicator_i, ack_i,
        input  alarm_state_o, alarm_blink_o, alarm_cause_o, new_fault_o
    );

    modport slave (
        input  enable_i, low_level_indicator_i, error_indicator_i, ack_i,
        output alarm_state_o, alarm_blink_o, alarm_cause_o, new_fault_o
    );
endinterface

// File: rtl/alarm_controller.sv
// alarm_controller: debounced per-channel fault monitor with ack/blink alarm FSM
module alarm_controller #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int BLINK_HALF      = 2
) (
    input logic     clk_i,
    input logic     rst_i,
    alarm_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, ACKED} state_t;

    state_t          state, nxt;
    logic [N_CH-1:0] raw, filtered, filt_d, rise;
    logic [CW-1:0]   cnt [N_CH];
    logic [BW-1:0]   bcnt;
    logic            en_d, any_rise, any_fault, ack_ok, entry;

    assign raw             = bus.error_indicator_i | ~bus.low_level_indicator_i;
    assign bus.new_fault_o = any_rise;

    // Each channel flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filtered <= '0;
            for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (raw[k] == filtered[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] >= CMAX) begin
                    filtered[k] <= raw[k];
                    cnt[k]      <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    // Rise detection (re-enable counts every held fault as new) and next-state selection
    always_comb begin
        rise      = bus.enable_i ? filtered & ~(filt_d & {N_CH{en_d}}) : '0;
        any_rise  = |rise;
        any_fault = |filtered;
        ack_ok    = state == ACTIVE && bus.ack_i && !any_rise;
        nxt       = !bus.enable_i                 ? IDLE :
                    any_rise                      ? ACTIVE :
                    ack_ok                        ? (any_fault ? ACKED : IDLE) :
                    state == ACKED && !any_fault  ? IDLE : state;
        entry     = nxt == ACTIVE && state != ACTIVE;
    end

    // Alarm FSM with registered state, cause and blink outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= IDLE;
            filt_d            <= '0;
            en_d              <= 1'b0;
            bcnt              <= '0;
            bus.alarm_state_o <= 1'b0;
            bus.alarm_blink_o <= 1'b0;
            bus.alarm_cause_o <= '0;
        end else begin
            state             <= nxt;
            filt_d            <= filtered;
            en_d              <= bus.enable_i;
            bus.alarm_state_o <= nxt != IDLE;
            bus.alarm_cause_o <= nxt == IDLE ? '0 :
                                 ((ack_ok ? bus.alarm_cause_o & filtered : bus.alarm_cause_o) | rise);
            bcnt              <= (entry || nxt != ACTIVE || bcnt == BMAX) ? '0 : bcnt + 1'b1;
            bus.alarm_blink_o <= nxt == ACKED   ? 1'b1 :
                                 nxt != ACTIVE  ? 1'b0 :
                                 entry          ? 1'b1 :
                                 bcnt == BMAX   ? ~bus.alarm_blink_o : bus.alarm_blink_o;
        end
    end
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed scenarios plus randomized run against a behavioural model
module tb_alarm_controller;
    localparam int N  = 4;
    localparam int D  = 3;
    localparam int BH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alarm_if #(.N_CH(N)) bus();

    alarm_controller #(.N_CH(N), .DEBOUNCE_CYCLES(D), .BLINK_HALF(BH)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: raw history window, mode 0=quiet 1=alarming 2=acknowledged
    logic [N-1:0] m_hist [D];
    int           m_nhist;
    logic [N-1:0] m_filt, m_filt_d, m_cause;
    logic         m_en_d, m_alarm, m_blink, m_nf;
    int           m_mode, m_since;

    function automatic void m_reset();
        for (int i = 0; i < D; i++) m_hist[i] = '0;
        m_nhist  = 0;
        m_filt   = '0;
        m_filt_d = '0;
        m_cause  = '0;
        m_en_d   = 1'b0;
        m_alarm  = 1'b0;
        m_blink  = 1'b0;
        m_nf     = 1'b0;
        m_mode   = 0;
        m_since  = 0;
    endfunction

    // Apply one cycle of inputs, advance the model on the edge, return at the next falling edge
    task automatic step(input logic en, input logic [N-1:0] ll, input logic [N-1:0] er, input logic a);
        logic [N-1:0] raw, rise;
        int nm;
        logic flip;
        bus.enable_i = en;
        bus.low_level_indicator_i = ll;
        bus.error_indicator_i = er;
        bus.ack_i = a;
        @(posedge clk);
        raw  = er | ~ll;
        rise = en ? (m_filt & ~(m_en_d ? m_filt_d : '0)) : '0;
        if (!en) nm = 0;
        else if (rise != 0) nm = 1;
        else if (m_mode == 1 && a) nm = (m_filt != 0) ? 2 : 0;
        else if (m_mode == 2 && m_filt == 0) nm = 0;
        else nm = m_mode;
        if (nm == 0) m_cause = '0;
        else begin
            if (m_mode == 1 && a && rise == 0) m_cause = m_cause & m_filt;
            m_cause = m_cause | rise;
        end
        m_since = (nm == 1 && m_mode != 1) ? 0 : m_since + 1;
        m_mode  = nm;
        m_alarm = nm != 0;
        m_blink = nm == 2 || (nm == 1 && (m_since / BH) % 2 == 0);
        for (int i = D - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = raw;
        if (m_nhist < D) m_nhist++;
        m_filt_d = m_filt;
        for (int k = 0; k < N; k++) begin
            flip = m_nhist == D;
            for (int i = 0; i < D; i++) if (m_hist[i][k] == m_filt[k]) flip = 1'b0;
            if (flip) m_filt[k] = raw[k];
        end
        m_en_d = en;
        m_nf   = en & |(m_filt & ~m_filt_d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.enable_i = 1'b1;
        bus.low_level_indicator_i = '1;
        bus.error_indicator_i = '0;
        bus.ack_i = 1'b0;
        rst = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
        total++; if (bus.alarm_state_o !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", bus.alarm_state_o); end
        total++; if (bus.alarm_blink_o !== 1'b0) begin bad++; $display("FAIL reset_blink got=%b exp=0", bus.alarm_blink_o); end
        total++; if (bus.alarm_cause_o !== 4'b0000) begin bad++; $display("FAIL reset_cause got=%b exp=0000", bus.alarm_cause_o); end
        total++; if (bus.new_fault_o !== 1'b0) begin bad++; $display("FAIL reset_new_fault got=%b exp=0", bus.new_fault_o); end
        rst = 1'b0;
    endtask

    task automatic test_glitch();
        int pulses = 0;
        int st = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i < 2) ? 4'b1101 : 4'b1111, 4'b0000, 1'b0);
            pulses += int'(bus.new_fault_o);
            st += int'(bus.alarm_state_o);
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL glitch_new_fault got=%0d pulses exp=0", pulses); end
        total++; if (st != 0) begin bad++; $display("FAIL glitch_state got=%0d active cycles exp=0", st); end
    endtask

    task automatic test_alarm();
        logic [5:0] pat = 6'b110011;
        int pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 4'b1111, 4'b0100, 1'b0);
            pulses += int'(bus.new_fault_o);
            if (i == 3) begin
                total++; if (bus.new_fault_o !== 1'b1) begin bad++; $display("FAIL alarm_new_fault_edge3 got=%b exp=1", bus.new_fault_o); end
            end
            if (i == 4) begin
                total++; if (bus.alarm_state_o !== 1'b1) begin bad++; $display("FAIL alarm_state got=%b exp=1", bus.alarm_state_o); end
                total++; if (bus.alarm_cause_o !== 4'b0100) begin bad++; $display("FAIL alarm_cause got=%b exp=0100", bus.alarm_cause_o); end
            end
            if (i >= 4) begin
                total++; if (bus.alarm_blink_o !== pat[9-i]) begin bad++; $display("FAIL alarm_blink cyc=%0d got=%b exp=%b", i - 4, bus.alarm_blink_o, pat[9-i]); end
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL alarm_pulse_count got=%0d exp=1", pulses); end
    endtask

    task automatic test_ack();
        step(1'b1, 4'b1111, 4'b0100, 1'b1);
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.alarm_state_o !== 1'b1 || bus.alarm_blink_o !== 1'b1) begin bad++; $display("FAIL ack_steady cyc=%0d got=%b%b exp=11", i, bus.alarm_state_o, bus.alarm_blink_o); end
            step(1'b1, 4'b1111, 4'b0100, 1'b0);
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 4'b1111, 4'b0000, 1'b0);
            if (i == 3) begin
                total++; if (bus.alarm_state_o !== 1'b1) begin bad++; $display("FAIL ack_hold got=%b exp=1", bus.alarm_state_o); end
            end
        end
        total++; if ({bus.alarm_state_o, bus.alarm_blink_o, bus.alarm_cause_o, bus.new_fault_o} !== 7'b0) begin
            bad++; $display("FAIL ack_idle got=%b%b%b%b exp=all zero", bus.alarm_state_o, bus.alarm_blink_o, bus.alarm_cause_o, bus.new_fault_o);
        end
    endtask

    task automatic test_rise_ack();
        repeat (4) step(1'b1, 4'b1111, 4'b0001, 1'b0);
        step(1'b1, 4'b1111, 4'b0001, 1'b1);
        total++; if (bus.alarm_blink_o !== 1'b1 || bus.alarm_cause_o !== 4'b0001) begin bad++; $display("FAIL rise_ack_acked got=%b %b exp=1 0001", bus.alarm_blink_o, bus.alarm_cause_o); end
        repeat (3) step(1'b1, 4'b1111, 4'b1001, 1'b0);
        step(1'b1, 4'b1111, 4'b1001, 1'b1);
        total++; if (bus.alarm_state_o !== 1'b1 || m_mode != 1) begin bad++; $display("FAIL rise_ack_state got=%b mode=%0d exp=1 1", bus.alarm_state_o, m_mode); end
        total++; if (bus.alarm_cause_o !== 4'b1001) begin bad++; $display("FAIL rise_ack_cause got=%b exp=1001", bus.alarm_cause_o); end
        total++; if (bus.alarm_blink_o !== 1'b1) begin bad++; $display("FAIL rise_ack_blink0 got=%b exp=1", bus.alarm_blink_o); end
        step(1'b1, 4'b1111, 4'b1001, 1'b0);
        step(1'b1, 4'b1111, 4'b1001, 1'b0);
        total++; if (bus.alarm_blink_o !== 1'b0) begin bad++; $display("FAIL rise_ack_blink2 got=%b exp=0", bus.alarm_blink_o); end
    endtask

    task automatic test_clear_no_ack();
        repeat (6) step(1'b1, 4'b1111, 4'b0000, 1'b0);
        total++; if (bus.alarm_state_o !== 1'b1) begin bad++; $display("FAIL clear_state got=%b exp=1", bus.alarm_state_o); end
        total++; if (bus.alarm_cause_o !== 4'b1001) begin bad++; $display("FAIL clear_cause got=%b exp=1001", bus.alarm_cause_o); end
        step(1'b1, 4'b1111, 4'b0000, 1'b1);
        total++; if (bus.alarm_state_o !== 1'b0 || bus.alarm_cause_o !== 4'b0000) begin bad++; $display("FAIL clear_ack got=%b %b exp=0 0000", bus.alarm_state_o, bus.alarm_cause_o); end
    endtask

    task automatic test_async_reset();
        int edges = 0;
        repeat (4) step(1'b1, 4'b1111, 4'b0010, 1'b0);
        total++; if (bus.alarm_state_o !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b exp=1", bus.alarm_state_o); end
        #2 rst = 1'b1;
        #1;
        total++; if ({bus.alarm_state_o, bus.alarm_blink_o, bus.alarm_cause_o} !== 6'b0) begin
            bad++; $display("FAIL arst_clear got=%b%b%b exp=all zero", bus.alarm_state_o, bus.alarm_blink_o, bus.alarm_cause_o);
        end
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 20 && edges == 0; n++) begin
            step(1'b1, 4'b1111, 4'b0010, 1'b0);
            if (bus.alarm_state_o === 1'b1) edges = n;
        end
        total++; if (edges != D + 1) begin bad++; $display("FAIL arst_realarm got=%0d edges exp=%0d", edges, D + 1); end
    endtask

    task automatic test_enable();
        step(1'b0, 4'b1111, 4'b0010, 1'b0);
        total++; if (bus.alarm_state_o !== 1'b0 || bus.alarm_cause_o !== 4'b0000) begin bad++; $display("FAIL en_off got=%b %b exp=0 0000", bus.alarm_state_o, bus.alarm_cause_o); end
        repeat (3) step(1'b0, 4'b1111, 4'b0010, 1'b0);
        total++; if (bus.new_fault_o !== 1'b0) begin bad++; $display("FAIL en_off_nf got=%b exp=0", bus.new_fault_o); end
        bus.enable_i = 1'b1;
        #1;
        total++; if (bus.new_fault_o !== 1'b1) begin bad++; $display("FAIL en_return_nf got=%b exp=1", bus.new_fault_o); end
        step(1'b1, 4'b1111, 4'b0010, 1'b0);
        total++; if (bus.alarm_state_o !== 1'b1 || bus.alarm_cause_o !== 4'b0010) begin bad++; $display("FAIL en_realarm got=%b %b exp=1 0010", bus.alarm_state_o, bus.alarm_cause_o); end
    endtask

    task automatic test_random();
        logic [N-1:0] er = '0;
        logic [N-1:0] ll = '1;
        logic en, a;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                er = N'($urandom) & N'($urandom);
                ll = ~(N'($urandom) & N'($urandom) & N'($urandom));
            end
            en = $urandom_range(0, 19) != 0;
            a  = $urandom_range(0, 5) == 0;
            step(en, ll, er, a);
            total++; if (bus.alarm_state_o !== m_alarm) begin bad++; $display("FAIL rnd_state i=%0d got=%b exp=%b", i, bus.alarm_state_o, m_alarm); end
            total++; if (bus.alarm_blink_o !== m_blink) begin bad++; $display("FAIL rnd_blink i=%0d got=%b exp=%b", i, bus.alarm_blink_o, m_blink); end
            total++; if (bus.alarm_cause_o !== m_cause) begin bad++; $display("FAIL rnd_cause i=%0d got=%b exp=%b", i, bus.alarm_cause_o, m_cause); end
            total++; if (bus.new_fault_o !== m_nf) begin bad++; $display("FAIL rnd_new_fault i=%0d got=%b exp=%b", i, bus.new_fault_o, m_nf); end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_alarm();
        test_ack();
        test_rise_ack();
        test_clear_no_ack();
        test_async_reset();
        test_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter N_CH, default 4, number of monitored tank/sensor channels (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 3, consecutive stable samples needed to change a filtered fault (>=1).
REQ-003 Parameter BLINK_HALF, default 2, clock cycles per half-period of the unacknowledged blink (>=1).
REQ-004 clk_i  input  1  system clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 enable_i  input  1  alarm subsystem enable; 0 forces quiet state.
REQ-007 low_level_indicator_i  input  N_CH  per-channel level sensor; 0 = critical level.
REQ-008 error_indicator_i  input  N_CH  per-channel error flag; 1 = error.
REQ-009 ack_i  input  1  operator acknowledge, sampled as a level each cycle.
REQ-010 alarm_state_o  output  1  alarm active (unacknowledged or acknowledged).
REQ-011 alarm_blink_o  output  1  siren/lamp drive: blinking when unacknowledged, steady when acknowledged.
REQ-012 alarm_cause_o  output  N_CH  sticky per-channel cause bits.
REQ-013 new_fault_o  output  1  one-cycle pulse when any filtered fault rises.

Function
REQ-014 raw[k] SHALL equal error_indicator_i[k] OR NOT low_level_indicator_i[k].
REQ-015 Per channel, filtered[k] SHALL change only after raw[k] has differed from filtered[k] for DEBOUNCE_CYCLES consecutive sampling edges; it updates on that edge. Any sample equal to filtered[k] clears that channel's count.
REQ-016 Debounce counters SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits and SHALL saturate, never wrap.
REQ-017 rise[k] SHALL be 1 in the cycle after filtered[k] goes 0->1; new_fault_o SHALL equal OR of rise while enable_i=1.
REQ-018 FSM states: IDLE, ACTIVE, ACKED.
REQ-019 IDLE -> ACTIVE on any rise[k]; otherwise stay.
REQ-020 ACTIVE -> ACKED when ack_i=1 and at least one filtered bit is 1; ACTIVE -> IDLE when ack_i=1 and all filtered bits are 0; otherwise stay. Clearing faults without ack SHALL NOT leave ACTIVE.
REQ-021 ACKED -> ACTIVE on any rise[k]; ACKED -> IDLE when all filtered bits are 0; otherwise stay.
REQ-022 Rise and ack_i in the same cycle: rise wins, and the next state is ACTIVE.
REQ-023 alarm_cause_o[k] SHALL set on rise[k]. On an accepted ack it SHALL clear for channels with filtered[k]=0 and no rise. In IDLE it SHALL be 0.
REQ-024 alarm_state_o SHALL be 1 in ACTIVE or ACKED, and registered (one cycle after the state-changing edge).
REQ-025 alarm_blink_o: 0 in IDLE, 1 in ACKED. In ACTIVE it SHALL be 1 on entry and toggle every BLINK_HALF cycles. The blink counter restarts on every entry to ACTIVE.
REQ-026 enable_i=0 SHALL force the FSM to IDLE, cause to 0 and new_fault_o to 0; debounce keeps running.
REQ-027 On the cycle enable_i returns to 1, every channel with filtered[k]=1 SHALL be treated as a rise.

Reset
REQ-028 rst_i=1 SHALL immediately (no clock) clear the FSM to IDLE, all debounce counters to 0, filtered to 0, the blink counter to 0, and all outputs to 0.
REQ-029 Reset asserted mid-alarm SHALL discard all latched causes. After release, still-present faults SHALL re-alarm after DEBOUNCE_CYCLES+1 edges.

Verification (N_CH=4, DEBOUNCE_CYCLES=3, BLINK_HALF=2)
REQ-030 A bench SHALL drive low_level[1]=0 for 2 cycles then back to 1 -> no new_fault_o, alarm_state_o stays 0.
REQ-031 A bench SHALL drive error[2]=1 held -> new_fault_o pulses once, alarm_state_o=1, cause=4'b0100, and blink reads 1,1,0,0,1,1.
REQ-032 A bench SHALL, from ACTIVE with the channel-2 fault still present, pulse ack_i=1 -> state ACKED, blink steady 1; then clear error[2] -> after 3 cycles filtered clears and the state goes to IDLE with all outputs 0.
REQ-033 A bench SHALL, in ACKED on channel 0, raise a fault on channel 3 on the same edge as ack_i=1 -> state ACTIVE, cause=4'b1001, blink restarts at 1.
REQ-034 A bench SHALL, in ACTIVE, clear all faults without ack -> alarm_state_o stays 1, cause unchanged until ack_i, then IDLE.
REQ-035 A bench SHALL assert rst_i asynchronously between clock edges during ACTIVE -> outputs go 0 before the next edge; with the fault still held, re-alarm occurs 4 edges after release.
